// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request/ack bus between the CPU port and dmem_responder
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        ready;
  logic        ack;
  logic [31:0] dataOut;
  logic        error;

  modport master (
    output req, we, size, address, writeData,
    input  ready, ack, dataOut, error
  );

  modport slave (
    input  req, we, size, address, writeData,
    output ready, ack, dataOut, error
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle big-endian data memory responder with programmable wait states
// Optional DMEM_PERF_CNT_EN adds saturating load/store/error event counters.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [15:0]      loadCount,
  output logic [15:0]      storeCount,
  output logic [15:0]      errorCount
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam bit DIRECT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        err_q;
  logic [31:0] dout_q;
  logic        accept, access;

  logic        acc_we;
  logic [1:0]  acc_size;
  logic [31:0] acc_addr, acc_wdata;
  logic [32:0] last_byte;
  logic        acc_err;
  logic        mem_we;
  logic [AW-1:0] i0, i1, i2, i3;
  logic [31:0] rdata;
  logic [7:0]  mem [DEPTH];

  assign accept = (state == IDLE) && bus.req;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (DIRECT) begin
            state_nxt = RESP;
            access    = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          access    = 1'b1;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With no wait states the access happens on the accept edge, before anything is latched.
  assign acc_we    = DIRECT ? bus.we        : we_q;
  assign acc_size  = DIRECT ? bus.size      : size_q;
  assign acc_addr  = DIRECT ? bus.address   : addr_q;
  assign acc_wdata = DIRECT ? bus.writeData : wdata_q;

  assign last_byte = {1'b0, acc_addr} + ((acc_size == 2'd1) ? 33'd3 : 33'd1);
  assign acc_err   = (acc_size == 2'd0)
                   || ((acc_size == 2'd1) && (acc_addr[1:0] != 2'b00))
                   || (acc_size[1] && acc_addr[0])
                   || (last_byte >= 33'(DEPTH));

  assign i0 = acc_addr[AW-1:0];
  assign i1 = i0 + AW'(1);
  assign i2 = i0 + AW'(2);
  assign i3 = i0 + AW'(3);

  always_comb begin
    rdata = 32'h0;
    case (acc_size)
      2'd1:    rdata = {mem[i0], mem[i1], mem[i2], mem[i3]};
      2'd2:    rdata = {{16{mem[i0][7]}}, mem[i0], mem[i1]};
      2'd3:    rdata = {16'h0000, mem[i0], mem[i1]};
      default: rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      dout_q  <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= bus.we;
        size_q  <= bus.size;
        addr_q  <= bus.address;
        wdata_q <= bus.writeData;
      end
      if (access) begin
        err_q <= acc_err;
        if (acc_err)
          dout_q <= 32'h0;
        else if (!acc_we)
          dout_q <= rdata;
      end
    end
  end

  assign mem_we = access && acc_we && !acc_err;

  // Storage is never cleared; reset only blocks a commit while it is held.
  always_ff @(posedge clk or negedge reset) begin
    if (reset && mem_we) begin
      if (acc_size == 2'd1) begin
        mem[i0] <= acc_wdata[31:24];
        mem[i1] <= acc_wdata[23:16];
        mem[i2] <= acc_wdata[15:8];
        mem[i3] <= acc_wdata[7:0];
      end else begin
        mem[i0] <= acc_wdata[15:8];
        mem[i1] <= acc_wdata[7:0];
      end
    end
  end

  assign bus.ready   = (state == IDLE);
  assign bus.ack     = (state == RESP);
  assign bus.error   = (state == RESP) && err_q;
  assign bus.dataOut = dout_q;

`ifdef DMEM_PERF_CNT_EN
  logic [15:0] ld_cnt, st_cnt, err_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_cnt  <= 16'h0;
      st_cnt  <= 16'h0;
      err_cnt <= 16'h0;
    end else if (state == RESP) begin
      if (err_q) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end else if (we_q) begin
        if (st_cnt != 16'hFFFF) st_cnt <= st_cnt + 16'd1;
      end else begin
        if (ld_cnt != 16'hFFFF) ld_cnt <= ld_cnt + 16'd1;
      end
    end
  end

  assign loadCount  = ld_cnt;
  assign storeCount = st_cnt;
  assign errorCount = err_cnt;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (vector table, random ops, corner sequences)
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int WS    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus0();
  dmem_responder_if bus1();

`ifdef DMEM_PERF_CNT_EN
  logic [15:0] lc0, sc0, ec0, lc1, sc1, ec1;
`endif

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset), .bus(bus0)
`ifdef DMEM_PERF_CNT_EN
    , .loadCount(lc0), .storeCount(sc0), .errorCount(ec0)
`endif
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus1)
`ifdef DMEM_PERF_CNT_EN
    , .loadCount(lc1), .storeCount(sc1), .errorCount(ec1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model_mem [DEPTH];

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_d;
    logic        chk_d;
  } vec_t;
  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Byte-array reference: applies a request and returns the expected error/load data.
  function automatic void model(input logic we, input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, output logic err, output logic [31:0] d);
    int nb;
    int idx;
    logic [32:0] last;
    nb   = (sz == 2'd1) ? 4 : 2;
    last = {1'b0, a} + 33'(nb - 1);
    err  = (sz == 2'd0) || ((sz == 2'd1) && (a[1:0] != 2'b00)) || (sz[1] && a[0])
         || (last >= 33'(DEPTH));
    d = 32'h0;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        idx = int'(a) + i;
        if (we) model_mem[idx] = wd[8*(nb-1-i) +: 8];
        else    d = {d[23:0], model_mem[idx]};
      end
      if (!we && sz == 2'd2 && d[15]) d[31:16] = 16'hFFFF;
    end
  endfunction

  task automatic issue0(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic got_err, output logic [31:0] got_d);
    logic        exp_err;
    logic [31:0] exp_d;
    int          waited;
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = we; bus0.size = sz; bus0.address = a; bus0.writeData = wd;
    waited = 0;
    while (bus0.ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check1("accept_ready", bus0.ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus0.req = 1'b0;
    for (int c = 1; c <= WS; c++) begin
      check1("ack_early", bus0.ack, 1'b0);
      check1("error_outside_ack", bus0.error, 1'b0);
      @(negedge clk);
    end
    model(we, sz, a, wd, exp_err, exp_d);
    check1("ack_latency", bus0.ack, 1'b1);
    check1("error_flag", bus0.error, exp_err);
    if (!we || exp_err) check("load_data", bus0.dataOut, exp_d);
    got_err = bus0.error;
    got_d   = bus0.dataOut;
    @(negedge clk);
    check1("ack_one_cycle", bus0.ack, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ge;
    logic [31:0] gd;
    logic        rwe;
    logic [1:0]  rsz;
    logic [31:0] ra;
    logic [31:0] wv [4];
    logic [7:0]  saved [4];

    vecs[0]  = '{1'b1, 2'd1, 32'h10,       32'h11223344, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'd1, 32'h10,       32'h0,        1'b0, 32'h11223344, 1'b1};
    vecs[2]  = '{1'b0, 2'd2, 32'h10,       32'h0,        1'b0, 32'h00001122, 1'b1};
    vecs[3]  = '{1'b1, 2'd2, 32'h20,       32'h1234F0AB, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 2'd2, 32'h20,       32'h0,        1'b0, 32'hFFFFF0AB, 1'b1};
    vecs[5]  = '{1'b0, 2'd3, 32'h20,       32'h0,        1'b0, 32'h0000F0AB, 1'b1};
    vecs[6]  = '{1'b0, 2'd1, 32'h12,       32'h0,        1'b1, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 2'd2, 32'h11,       32'h0,        1'b1, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 2'd0, 32'h0,        32'h0,        1'b1, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 2'd1, 32'h3FE,      32'h0,        1'b1, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 2'd1, 32'h10,       32'h0,        1'b0, 32'h11223344, 1'b1};
    vecs[11] = '{1'b1, 2'd1, 32'h3FC,      32'hA5A55A5A, 1'b0, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 2'd1, 32'h3FC,      32'h0,        1'b0, 32'hA5A55A5A, 1'b1};
    vecs[13] = '{1'b0, 2'd3, 32'h3FE,      32'h0,        1'b0, 32'h00005A5A, 1'b1};
    vecs[14] = '{1'b0, 2'd1, 32'h400,      32'h0,        1'b1, 32'h0,        1'b1};
    vecs[15] = '{1'b1, 2'd2, 32'hFFFFFFFE, 32'h0000BEEF, 1'b1, 32'h0,        1'b0};
    vecs[16] = '{1'b1, 2'd0, 32'h30,       32'h01020304, 1'b1, 32'h0,        1'b0};
    vecs[17] = '{1'b0, 2'd2, 32'h3FC,      32'h0,        1'b0, 32'hFFFFA5A5, 1'b1};

    reset = 1'b0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.size = 2'd0; bus0.address = 32'h0; bus0.writeData = 32'h0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.size = 2'd0; bus1.address = 32'h0; bus1.writeData = 32'h0;
    repeat (2) @(negedge clk);
    check1("rst_ack", bus0.ack, 1'b0);
    check1("rst_error", bus0.error, 1'b0);
    check("rst_dataOut", bus0.dataOut, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check1("rst_ready", bus0.ready, 1'b1);
    check1("rst_ready_ws0", bus1.ready, 1'b1);

    // Give every byte a known value so all later loads are predictable.
    for (int i = 0; i < DEPTH / 4; i++) issue0(1'b1, 2'd1, 32'(4 * i), $urandom, ge, gd);

    for (int v = 0; v < 18; v++) begin
      issue0(vecs[v].we, vecs[v].sz, vecs[v].a, vecs[v].wd, ge, gd);
      check1($sformatf("vec%0d_error", v), ge, vecs[v].exp_err);
      if (vecs[v].chk_d) check($sformatf("vec%0d_data", v), gd, vecs[v].exp_d);
    end

    for (int n = 0; n < 300; n++) begin
      rwe = 1'($urandom_range(0, 1));
      rsz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ra = $urandom;
      else ra = 32'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) != 0) ra = (rsz == 2'd1) ? {ra[31:2], 2'b00} : {ra[31:1], 1'b0};
      issue0(rwe, rsz, ra, $urandom, ge, gd);
    end

    // Zero wait states with req held high: accept and ack alternate every cycle.
    for (int k = 0; k < 4; k++) wv[k] = $urandom;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check1("ws0_ready_idle", bus1.ready, 1'b1);
      check1("ws0_ack_idle", bus1.ack, 1'b0);
      bus1.req = 1'b1; bus1.we = (k < 4); bus1.size = 2'd1;
      bus1.address = 32'(4 * (k % 4)); bus1.writeData = wv[k % 4];
      @(negedge clk);
      check1("ws0_ready_resp", bus1.ready, 1'b0);
      check1("ws0_ack_resp", bus1.ack, 1'b1);
      check1("ws0_error", bus1.error, 1'b0);
      if (k >= 4) check("ws0_load", bus1.dataOut, wv[k - 4]);
      if (k == 7) bus1.req = 1'b0;
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      check1("ws0_no_extra_ack", bus1.ack, 1'b0);
      @(negedge clk);
    end
`ifdef DMEM_PERF_CNT_EN
    check("ws0_loadCount", 32'(lc1), 32'd4);
    check("ws0_storeCount", 32'(sc1), 32'd4);
    check("ws0_errorCount", 32'(ec1), 32'd0);
`endif

    // Reset during BUSY discards the pending store and its ack.
    for (int i = 0; i < 4; i++) saved[i] = model_mem[32'h40 + i];
    @(negedge clk);
    check1("rst_mid_ready", bus0.ready, 1'b1);
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.size = 2'd1; bus0.address = 32'h40; bus0.writeData = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    bus0.req = 1'b0;
    check1("rst_mid_busy", bus0.ready, 1'b0);
    reset = 1'b0;
    #1;
    check1("rst_mid_ack", bus0.ack, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check1("rst_mid_no_ack", bus0.ack, 1'b0);
      @(negedge clk);
    end
    check1("rst_mid_ready_after", bus0.ready, 1'b1);
    issue0(1'b0, 2'd1, 32'h40, 32'h0, ge, gd);
    check("rst_mid_unchanged", gd, {saved[0], saved[1], saved[2], saved[3]});

`ifdef DMEM_PERF_CNT_EN
    issue0(1'b0, 2'd3, 32'h10, 32'h0, ge, gd);
    issue0(1'b0, 2'd2, 32'h20, 32'h0, ge, gd);
    issue0(1'b1, 2'd1, 32'h50, 32'hCAFEF00D, ge, gd);
    issue0(1'b1, 2'd3, 32'h60, 32'h00001357, ge, gd);
    issue0(1'b0, 2'd1, 32'h41, 32'h0, ge, gd);
    check("perf_loadCount", 32'(lc0), 32'd3);
    check("perf_storeCount", 32'(sc0), 32'd2);
    check("perf_errorCount", 32'(ec0), 32'd1);
    @(negedge clk);
    force u_dut.err_cnt = 16'hFFFF;
    @(negedge clk);
    release u_dut.err_cnt;
    issue0(1'b0, 2'd0, 32'h0, 32'h0, ge, gd);
    check("perf_errorCount_sat", 32'(ec0), 32'h0000FFFF);
    check("perf_loadCount_after_err", 32'(lc0), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
